axi_rd_req_scheduler: RTL and testbench
=======================================

// Module: axi_rd_req_scheduler
// PURPOSE
//  Shares one AXI4 read address/data channel pair among NrPorts requesters (I$ refill, D$ refill, PTW).
//  Arbitrates round-robin and allocates a free AXI ID per transaction from a pool of 2**AxiIdWidth.
//  Caps in-flight reads at MaxOutstanding and routes R beats back to the owning port by ID.
//  Sits between cache/MMU miss logic and the AXI NoC master port.
// PARAMETERS
//  NrPorts         3    number of requesters (>=2)
//  AxiIdWidth      4    AR/R ID width; ID pool depth = 2**AxiIdWidth
//  AxiAddrWidth    64   request/AR address width
//  AxiDataWidth    64   R data width
//  MaxOutstanding  7    max in-flight reads, 1..2**AxiIdWidth
// PORTS
//  clk_i          in   1                      clock
//  rst_ni         in   1                      reset, asynchronous, active-low
//  req_valid_i    in   NrPorts                requester read request
//  req_ready_o    out  NrPorts                request granted (one-hot or zero)
//  req_addr_i     in   NrPorts*AxiAddrWidth   per-port address
//  req_len_i      in   NrPorts*8              per-port AXI len (beats-1)
//  ar_valid_o     out  1                      AR valid
//  ar_ready_i     in   1                      AR ready
//  ar_addr_o      out  AxiAddrWidth           AR address
//  ar_len_o       out  8                      AR len
//  ar_id_o        out  AxiIdWidth             AR ID
//  r_valid_i      in   1                      R valid
//  r_ready_o      out  1                      R ready
//  r_id_i         in   AxiIdWidth             R ID
//  r_data_i       in   AxiDataWidth           R data
//  r_resp_i       in   2                      R resp
//  r_last_i       in   1                      R last
//  rsp_valid_o    out  NrPorts                beat valid to owning port (one-hot or zero)
//  rsp_ready_i    in   NrPorts                per-port beat ready
//  rsp_data_o     out  AxiDataWidth           beat data, broadcast
//  rsp_last_o     out  1                      last beat, broadcast
//  rsp_err_o      out  1                      r_resp_i[1] set (SLVERR/DECERR), broadcast
//  outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight count
//  proto_err_o    out  1                      sticky: R beat for an unallocated ID
// BEHAVIOUR
//  Reset values: ar_valid_o=0, AR payload 0, all IDs free, count=0, RR pointer=0, proto_err_o=0.
//  AR slot FSM with two states. IDLE: ar_valid_o=0. PEND: ar_valid_o=1, payload held stable until ar_ready_i.
//  Grant condition: (IDLE or (PEND & ar_ready_i)) & any free ID & count<MaxOutstanding & any req_valid_i.
//  Grant: winner is the first requesting port at or after the RR pointer. req_ready_o[winner]=1 in the same cycle (comb).
//   The AR slot loads {addr,len,lowest free ID}. The ID is marked busy with owner=winner. The pointer moves to (winner+1)%NrPorts. State goes to PEND.
//  PEND & ar_ready_i & no grant -> IDLE. Latency from req to ar_valid_o is 1 cycle. Back-to-back grants are allowed, one per cycle.
//  R path (comb): o = owner[r_id_i]. rsp_valid_o[o]=r_valid_i, r_ready_o=rsp_ready_i[o], data/last/err passed straight through.
//  The ID is freed on r_valid_i & r_ready_o & r_last_i.
//  Unallocated r_id_i: r_ready_o=1, rsp_valid_o=0, beat dropped, proto_err_o set until reset.
//  Same cycle free+grant: the allocator sees the pre-free pool, so a freed ID is not reused that cycle. count += grant - free.
//  Full (count==MaxOutstanding or no free ID): req_ready_o=0; an already pending AR still completes.
//  Pointer wraps NrPorts-1 -> 0. len=0 means single beat, first beat carries last.
//  Reset mid-operation clears everything; in-flight reads are abandoned, and the NoC and requesters must reset together.
// STRUCTURE
//  Shared package: axi_rd_sched_pkg
//   - typedef id_t (AxiIdWidth bits)
//   - typedef port_idx_t ($clog2(NrPorts) bits)
//   - typedef ar_req_t {addr, len, id}
//   - localparam NrIds = 2**AxiIdWidth
//  Sub-module: axi_rd_id_pool holds the busy bitmap, owner table, lowest-free encoder and in-flight counter.
//   Its ports are alloc/free strobes, the allocated ID, owner lookup and the full flag.
//  The top level holds the RR arbiter, the AR slot FSM and the R routing.
// TESTING
//  1 Single read: port1 addr=0x8000_0040 len=1 -> ar_id_o=0 one cycle later. 2 beats routed to port1, last on beat 2, ID 0 freed, count back to 0.
//  2 Fairness: all 3 ports valid continuously, ar_ready_i=1 -> grants 0,1,2,0,1,2 with IDs 0..5.
//  3 Cap: 7 reads in flight -> req_ready_o=0. One R last -> grant the next cycle, and the grant does not reuse the just-freed ID.
//  4 Out-of-order: IDs 2 and 0 interleave on R with rsp_ready_i toggling -> each beat reaches its owner only, no beat lost.
//  5 Errors: r_resp_i=2'b10 -> rsp_err_o=1 on that beat. Beat with unallocated ID 9 -> dropped, proto_err_o=1 and sticky.
//  6 AR backpressure: ar_ready_i=0 for 5 cycles -> payload stable and no extra grants. Assert rst_ni mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/axi_rd_sched_pkg.sv
// Shared configuration and types for the AXI read request scheduler slice.
// Widths live here so the pool, interface and top stay consistent.
package axi_rd_sched_pkg;

  localparam int unsigned NrPorts        = 3;
  localparam int unsigned AxiIdWidth     = 4;
  localparam int unsigned AxiAddrWidth   = 64;
  localparam int unsigned AxiDataWidth   = 64;
  localparam int unsigned MaxOutstanding = 7;

  localparam int unsigned NrIds        = 2 ** AxiIdWidth;
  localparam int unsigned PortIdxWidth = $clog2(NrPorts);
  localparam int unsigned CntWidth     = $clog2(MaxOutstanding + 1);

  typedef logic [AxiIdWidth-1:0]   id_t;
  typedef logic [PortIdxWidth-1:0] port_idx_t;
  typedef logic [CntWidth-1:0]     cnt_t;
  typedef logic [AxiAddrWidth-1:0] addr_t;
  typedef logic [AxiDataWidth-1:0] data_t;
  typedef logic [7:0]              len_t;

  typedef struct packed {
    addr_t addr;
    len_t  len;
    id_t   id;
  } ar_req_t;

  typedef enum logic {
    AR_IDLE,
    AR_PEND
  } ar_state_e;

endpackage

// File: rtl/axi_rd_req_scheduler_if.sv
// AXI4 read address and read data channels between the scheduler (master)
// and the NoC (slave).
interface axi_rd_req_scheduler_if;
  import axi_rd_sched_pkg::*;

  logic       ar_valid;
  logic       ar_ready;
  addr_t      ar_addr;
  len_t       ar_len;
  id_t        ar_id;

  logic       r_valid;
  logic       r_ready;
  id_t        r_id;
  data_t      r_data;
  logic [1:0] r_resp;
  logic       r_last;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_id, r_ready,
    input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_id, r_ready,
    output ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );

endinterface

// File: rtl/axi_rd_id_pool.sv
// AXI ID pool: busy bitmap, per-ID owner table, lowest-free encoder and
// in-flight counter.
module axi_rd_id_pool
  import axi_rd_sched_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      alloc_i,
  input  port_idx_t alloc_owner_i,
  output id_t       alloc_id_o,
  input  logic      free_i,
  input  id_t       free_id_i,
  input  id_t       lookup_id_i,
  output port_idx_t lookup_owner_o,
  output logic      lookup_busy_o,
  output logic      full_o,
  output cnt_t      count_o
);

  logic [NrIds-1:0] busy_q;
  port_idx_t        owner_q [NrIds];
  cnt_t             count_q;
  logic             any_free;

  // Encoder works on the registered bitmap, so an ID freed this cycle is
  // never handed out again in the same cycle.
  always_comb begin
    alloc_id_o = '0;
    any_free   = 1'b0;
    for (int unsigned i = 0; i < NrIds; i++) begin
      if (!busy_q[i] && !any_free) begin
        alloc_id_o = id_t'(i);
        any_free   = 1'b1;
      end
    end
  end

  always_comb begin
    full_o         = !any_free || (count_q == cnt_t'(MaxOutstanding));
    lookup_owner_o = owner_q[lookup_id_i];
    lookup_busy_o  = busy_q[lookup_id_i];
    count_o        = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < NrIds; i++) begin
        owner_q[i] <= '0;
      end
    end else begin
      if (free_i) begin
        busy_q[free_id_i] <= 1'b0;
      end
      if (alloc_i) begin
        busy_q[alloc_id_o]  <= 1'b1;
        owner_q[alloc_id_o] <= alloc_owner_i;
      end
      if (alloc_i && !free_i) begin
        count_q <= count_q + 1'b1;
      end else if (!alloc_i && free_i) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_req_scheduler.sv
// Shares one AXI4 AR/R channel pair among NrPorts requesters: round-robin
// arbitration, per-transaction ID allocation and ID-based R beat routing.
module axi_rd_req_scheduler
  import axi_rd_sched_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrPorts-1:0]              req_valid_i,
  output logic [NrPorts-1:0]              req_ready_o,
  input  logic [NrPorts*AxiAddrWidth-1:0] req_addr_i,
  input  logic [NrPorts*8-1:0]            req_len_i,
  axi_rd_req_scheduler_if.master          axi,
  output logic [NrPorts-1:0]              rsp_valid_o,
  input  logic [NrPorts-1:0]              rsp_ready_i,
  output data_t                           rsp_data_o,
  output logic                            rsp_last_o,
  output logic                            rsp_err_o,
  output cnt_t                            outstanding_o,
  output logic                            proto_err_o
);

  ar_state_e state_q, state_d;
  ar_req_t   ar_q;
  port_idx_t rr_ptr_q;
  port_idx_t winner, win_hi, win_lo;
  logic      hit_hi, hit_lo, any_req;
  addr_t     win_addr;
  len_t      win_len;
  logic      grant, pool_full;
  id_t       alloc_id;
  port_idx_t r_owner;
  logic      r_busy, r_free;
  logic      proto_err_q;
  logic      unused_resp_lsb;

  // Round robin: prefer the lowest requester at or above the pointer,
  // otherwise wrap to the lowest requester overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      if (req_valid_i[i]) begin
        if (!hit_lo) begin
          win_lo = port_idx_t'(i);
          hit_lo = 1'b1;
        end
        if (!hit_hi && (port_idx_t'(i) >= rr_ptr_q)) begin
          win_hi = port_idx_t'(i);
          hit_hi = 1'b1;
        end
      end
    end
    any_req = hit_lo;
    winner  = hit_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      if (port_idx_t'(i) == winner) begin
        win_addr = req_addr_i[i*AxiAddrWidth +: AxiAddrWidth];
        win_len  = req_len_i[i*8 +: 8];
      end
    end
  end

  assign grant = ((state_q == AR_IDLE) || axi.ar_ready) && !pool_full && any_req;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      req_ready_o[i] = grant && (port_idx_t'(i) == winner);
    end
  end

  // AR slot FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= AR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_IDLE: if (grant) state_d = AR_PEND;
      AR_PEND: if (axi.ar_ready && !grant) state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    axi.ar_valid = (state_q == AR_PEND);
    axi.ar_addr  = ar_q.addr;
    axi.ar_len   = ar_q.len;
    axi.ar_id    = ar_q.id;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_q     <= '0;
      rr_ptr_q <= '0;
    end else if (grant) begin
      ar_q     <= '{addr: win_addr, len: win_len, id: alloc_id};
      rr_ptr_q <= (winner == port_idx_t'(NrPorts - 1)) ? '0 : winner + 1'b1;
    end
  end

  axi_rd_id_pool u_id_pool (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .alloc_i        (grant),
    .alloc_owner_i  (winner),
    .alloc_id_o     (alloc_id),
    .free_i         (r_free),
    .free_id_i      (axi.r_id),
    .lookup_id_i    (axi.r_id),
    .lookup_owner_o (r_owner),
    .lookup_busy_o  (r_busy),
    .full_o         (pool_full),
    .count_o        (outstanding_o)
  );

  // Beats for IDs nobody owns are accepted and discarded so the bus cannot stall.
  always_comb begin
    rsp_valid_o = '0;
    axi.r_ready = 1'b1;
    if (r_busy) begin
      for (int unsigned i = 0; i < NrPorts; i++) begin
        if (port_idx_t'(i) == r_owner) begin
          rsp_valid_o[i] = axi.r_valid;
          axi.r_ready    = rsp_ready_i[i];
        end
      end
    end
  end

  assign r_free          = axi.r_valid && axi.r_ready && axi.r_last && r_busy;
  assign rsp_data_o      = axi.r_data;
  assign rsp_last_o      = axi.r_last;
  assign rsp_err_o       = axi.r_resp[1];
  assign unused_resp_lsb = axi.r_resp[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_q <= 1'b0;
    end else if (axi.r_valid && !r_busy) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_axi_rd_req_scheduler.sv
// Directed bench for axi_rd_req_scheduler with hand-computed expectations.
module tb_axi_rd_req_scheduler;
  import axi_rd_sched_pkg::*;

  logic                            clk_i = 1'b0;
  logic                            rst_ni;
  logic [NrPorts-1:0]              req_valid_i;
  logic [NrPorts-1:0]              req_ready_o;
  logic [NrPorts*AxiAddrWidth-1:0] req_addr_i;
  logic [NrPorts*8-1:0]            req_len_i;
  logic [NrPorts-1:0]              rsp_valid_o;
  logic [NrPorts-1:0]              rsp_ready_i;
  data_t                           rsp_data_o;
  logic                            rsp_last_o;
  logic                            rsp_err_o;
  cnt_t                            outstanding_o;
  logic                            proto_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  axi_rd_req_scheduler_if axi ();

  axi_rd_req_scheduler dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_len_i     (req_len_i),
    .axi           (axi),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .rsp_last_o    (rsp_last_o),
    .rsp_err_o     (rsp_err_o),
    .outstanding_o (outstanding_o),
    .proto_err_o   (proto_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int p, input logic [63:0] addr, input logic [7:0] len);
    req_addr_i[p*AxiAddrWidth +: AxiAddrWidth] = addr;
    req_len_i[p*8 +: 8] = len;
  endtask

  task automatic rbeat(input logic [3:0] id, input logic [63:0] d, input logic last,
                       input logic [1:0] resp);
    axi.r_valid = 1'b1;
    axi.r_id    = id;
    axi.r_data  = d;
    axi.r_last  = last;
    axi.r_resp  = resp;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_ar_valid"}, 64'(axi.ar_valid), 64'h0);
    chk({pfx, "_ar_addr"}, 64'(axi.ar_addr), 64'h0);
    chk({pfx, "_ar_id"}, 64'(axi.ar_id), 64'h0);
    chk({pfx, "_outstanding"}, 64'(outstanding_o), 64'h0);
    chk({pfx, "_proto_err"}, 64'(proto_err_o), 64'h0);
    chk({pfx, "_req_ready"}, 64'(req_ready_o), 64'h0);
  endtask

  initial begin
    logic [2:0] exp_rdy;
    rst_ni       = 1'b0;
    req_valid_i  = '0;
    req_addr_i   = '0;
    req_len_i    = '0;
    rsp_ready_i  = '1;
    axi.ar_ready = 1'b0;
    axi.r_valid  = 1'b0;
    axi.r_id     = '0;
    axi.r_data   = '0;
    axi.r_resp   = '0;
    axi.r_last   = 1'b0;
    #12;
    chk_reset_state("reset");
    rst_ni = 1'b1;
    tick();

    // 1: single two-beat read from port 1
    set_req(1, 64'h8000_0040, 8'd1);
    req_valid_i = 3'b010;
    #1 chk("t1_req_ready", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = '0;
    #1;
    chk("t1_ar_valid", 64'(axi.ar_valid), 64'h1);
    chk("t1_ar_addr", 64'(axi.ar_addr), 64'h8000_0040);
    chk("t1_ar_len", 64'(axi.ar_len), 64'h1);
    chk("t1_ar_id", 64'(axi.ar_id), 64'h0);
    chk("t1_outstanding", 64'(outstanding_o), 64'h1);
    axi.ar_ready = 1'b1;
    tick();
    axi.ar_ready = 1'b0;
    #1 chk("t1_ar_done", 64'(axi.ar_valid), 64'h0);
    rbeat(4'd0, 64'hA1A1_0001, 1'b0, 2'b00);
    #1;
    chk("t1_b1_valid", 64'(rsp_valid_o), 64'h2);
    chk("t1_b1_rready", 64'(axi.r_ready), 64'h1);
    chk("t1_b1_data", 64'(rsp_data_o), 64'hA1A1_0001);
    chk("t1_b1_last", 64'(rsp_last_o), 64'h0);
    tick();
    rbeat(4'd0, 64'hA1A1_0002, 1'b1, 2'b00);
    #1;
    chk("t1_b2_valid", 64'(rsp_valid_o), 64'h2);
    chk("t1_b2_last", 64'(rsp_last_o), 64'h1);
    tick();
    axi.r_valid = 1'b0;
    #1 chk("t1_count_back", 64'(outstanding_o), 64'h0);

    // 2: fairness from a fresh pointer
    rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    set_req(0, 64'h1000, 8'd0);
    set_req(1, 64'h2000, 8'd1);
    set_req(2, 64'h3000, 8'd2);
    req_valid_i  = 3'b111;
    axi.ar_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 3'b001 << (k % 3);
      #1 chk("t2_req_ready", 64'(req_ready_o), 64'(exp_rdy));
      tick();
      chk("t2_ar_id", 64'(axi.ar_id), 64'(k));
      chk("t2_ar_addr", 64'(axi.ar_addr), 64'(32'h1000 * (k % 3 + 1)));
    end
    req_valid_i = '0;
    tick();
    #1;
    chk("t2_outstanding", 64'(outstanding_o), 64'h6);
    chk("t2_ar_idle", 64'(axi.ar_valid), 64'h0);

    // 3: cap at seven, then free + grant in the same cycle
    set_req(0, 64'h4000, 8'd0);
    req_valid_i = 3'b001;
    #1 chk("t3_grant_id6", 64'(req_ready_o), 64'h1);
    tick();
    #1;
    chk("t3_ar_id6", 64'(axi.ar_id), 64'h6);
    chk("t3_count7", 64'(outstanding_o), 64'h7);
    chk("t3_full_block", 64'(req_ready_o), 64'h0);
    rbeat(4'd5, 64'hC0C0, 1'b1, 2'b00);
    #1;
    chk("t3_full_during_free", 64'(req_ready_o), 64'h0);
    chk("t3_id5_owner", 64'(rsp_valid_o), 64'h4);
    tick();
    rbeat(4'd0, 64'hC0C1, 1'b1, 2'b00);
    #1;
    chk("t3_count_after_free", 64'(outstanding_o), 64'h6);
    chk("t3_grant_after_free", 64'(req_ready_o), 64'h1);
    chk("t3_id0_owner", 64'(rsp_valid_o), 64'h1);
    tick();
    axi.r_valid = 1'b0;
    req_valid_i = '0;
    #1;
    chk("t3_no_reuse_id", 64'(axi.ar_id), 64'h5);
    chk("t3_count_net", 64'(outstanding_o), 64'h6);
    tick();

    // 4: IDs 2 (port 2) and 0 (port 1) interleave under backpressure
    set_req(1, 64'h5000, 8'd1);
    req_valid_i = 3'b010;
    #1 chk("t4_grant", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = '0;
    #1 chk("t4_ar_id0", 64'(axi.ar_id), 64'h0);
    tick();
    rbeat(4'd2, 64'hB000, 1'b0, 2'b00);
    rsp_ready_i = 3'b000;
    #1;
    chk("t4_s1_valid", 64'(rsp_valid_o), 64'h4);
    chk("t4_s1_stall", 64'(axi.r_ready), 64'h0);
    tick();
    rsp_ready_i = 3'b100;
    #1 chk("t4_s2_ready", 64'(axi.r_ready), 64'h1);
    tick();
    rbeat(4'd0, 64'hC000, 1'b0, 2'b00);
    #1;
    chk("t4_s3_valid", 64'(rsp_valid_o), 64'h2);
    chk("t4_s3_stall", 64'(axi.r_ready), 64'h0);
    tick();
    rsp_ready_i = 3'b010;
    #1;
    chk("t4_s4_ready", 64'(axi.r_ready), 64'h1);
    chk("t4_s4_data", 64'(rsp_data_o), 64'hC000);
    tick();
    rbeat(4'd2, 64'hB001, 1'b1, 2'b00);
    rsp_ready_i = 3'b111;
    #1;
    chk("t4_s5_valid", 64'(rsp_valid_o), 64'h4);
    chk("t4_s5_data", 64'(rsp_data_o), 64'hB001);
    tick();
    rbeat(4'd0, 64'hC001, 1'b1, 2'b00);
    rsp_ready_i = 3'b011;
    #1;
    chk("t4_s6_valid", 64'(rsp_valid_o), 64'h2);
    chk("t4_s6_ready", 64'(axi.r_ready), 64'h1);
    tick();
    axi.r_valid = 1'b0;
    rsp_ready_i = '1;
    #1 chk("t4_count", 64'(outstanding_o), 64'h5);

    // 5: error response and an unallocated ID
    rbeat(4'd1, 64'hE000, 1'b1, 2'b10);
    #1;
    chk("t5_err", 64'(rsp_err_o), 64'h1);
    chk("t5_err_valid", 64'(rsp_valid_o), 64'h2);
    chk("t5_proto_clear", 64'(proto_err_o), 64'h0);
    tick();
    rbeat(4'd9, 64'hDEAD, 1'b1, 2'b00);
    #1;
    chk("t5_drop_valid", 64'(rsp_valid_o), 64'h0);
    chk("t5_drop_ready", 64'(axi.r_ready), 64'h1);
    chk("t5_err_okay", 64'(rsp_err_o), 64'h0);
    tick();
    axi.r_valid = 1'b0;
    #1;
    chk("t5_proto_set", 64'(proto_err_o), 64'h1);
    chk("t5_count", 64'(outstanding_o), 64'h4);
    tick();
    chk("t5_proto_sticky", 64'(proto_err_o), 64'h1);

    // 6: AR backpressure, then asynchronous reset mid-burst
    axi.ar_ready = 1'b0;
    set_req(2, 64'h6000, 8'd0);
    req_valid_i = 3'b100;
    #1 chk("t6_grant", 64'(req_ready_o), 64'h4);
    tick();
    req_valid_i = 3'b111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t6_hold_valid", 64'(axi.ar_valid), 64'h1);
      chk("t6_hold_addr", 64'(axi.ar_addr), 64'h6000);
      chk("t6_hold_len", 64'(axi.ar_len), 64'h0);
      chk("t6_hold_id", 64'(axi.ar_id), 64'h0);
      chk("t6_no_grant", 64'(req_ready_o), 64'h0);
      tick();
    end
    chk("t6_count", 64'(outstanding_o), 64'h5);
    #2;
    req_valid_i = '0;
    rst_ni      = 1'b0;
    #1 chk_reset_state("t6_async");
    #3 rst_ni = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
